// File: rtl/if_icache.sv
// Direct-mapped read-only instruction cache with whole-line refill over a word-wide bus.
// Optional hit/miss counters are enabled by defining ICACHE_STATS_EN.
module if_icache #(
    parameter int LINES          = 8,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] inst_mem_read_addr,
    input  logic        inst_mem_read_enable,
    output logic [31:0] inst_mem_read_data,
    output logic        inst_valid,
    output logic        fetch_stall,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);

    localparam int WB  = $clog2(WORDS_PER_LINE);
    localparam int OFF = WB + 2;
    localparam int IB  = $clog2(LINES);
    localparam int TB  = 32 - IB - OFF;
    localparam logic [WB-1:0] LAST_BEAT = WB'(WORDS_PER_LINE - 1);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_REFILL = 1'b1
    } state_t;

    state_t             r_state;
    logic [LINES-1:0]   r_valid;
    logic [TB-1:0]      r_tag  [LINES];
    logic [31:0]        r_data [LINES*WORDS_PER_LINE];
    logic [IB-1:0]      r_fill_idx;
    logic [TB-1:0]      r_fill_tag;
    logic [WB-1:0]      r_beat;
    logic               r_mem_req;
    logic [31:0]        r_mem_addr;

    logic [IB-1:0]      w_idx;
    logic [WB-1:0]      w_word;
    logic [TB-1:0]      w_tag;
    logic               w_hit;
    logic               w_miss;
    logic               w_beat_ok;
    logic               w_last;
    logic               w_unused_addr_bits;

    assign w_idx  = inst_mem_read_addr[OFF +: IB];
    assign w_word = inst_mem_read_addr[2 +: WB];
    assign w_tag  = inst_mem_read_addr[OFF+IB +: TB];
    assign w_unused_addr_bits = &{1'b0, inst_mem_read_addr[1:0]};

    // Lookup, hit/miss decode and the combinational fetch-side responses.
    always_comb begin
        w_hit              = 1'b0;
        w_miss             = 1'b0;
        inst_valid         = 1'b0;
        inst_mem_read_data = 32'd0;
        fetch_stall        = 1'b0;
        if (inst_mem_read_enable && (r_state == ST_IDLE)) begin
            if (r_valid[w_idx] && (r_tag[w_idx] == w_tag)) begin
                w_hit = 1'b1;
            end else begin
                w_miss = 1'b1;
            end
        end else begin
            w_hit  = 1'b0;
            w_miss = 1'b0;
        end
        if (w_hit) begin
            inst_valid         = 1'b1;
            inst_mem_read_data = r_data[{w_idx, w_word}];
        end else begin
            inst_valid         = 1'b0;
            inst_mem_read_data = 32'd0;
        end
        fetch_stall = w_miss || (r_state == ST_REFILL);
    end

    // mem_ready only counts while a beat is actually being requested.
    assign w_beat_ok = (r_state == ST_REFILL) && r_mem_req && mem_ready;
    assign w_last    = w_beat_ok && (r_beat == LAST_BEAT);

    // Refill FSM: latches the missing line, walks the beats, validates at the end.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_valid    <= '0;
            r_fill_idx <= '0;
            r_fill_tag <= '0;
            r_beat     <= '0;
            r_mem_req  <= 1'b0;
            r_mem_addr <= 32'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_miss) begin
                        r_state    <= ST_REFILL;
                        r_fill_idx <= w_idx;
                        r_fill_tag <= w_tag;
                        r_beat     <= '0;
                        r_mem_req  <= 1'b1;
                        r_mem_addr <= {inst_mem_read_addr[31:OFF], {OFF{1'b0}}};
                    end
                end
                ST_REFILL: begin
                    if (w_last) begin
                        r_valid[r_fill_idx] <= 1'b1;
                        r_state    <= ST_IDLE;
                        r_beat     <= '0;
                        r_mem_req  <= 1'b0;
                        r_mem_addr <= 32'd0;
                    end else if (w_beat_ok) begin
                        r_beat     <= r_beat + WB'(1);
                        r_mem_addr <= r_mem_addr + 32'd4;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_mem_req <= 1'b0;
                end
            endcase
        end
    end

    // Line storage: data per beat, tag only once the whole line has arrived.
    always_ff @(posedge clk) begin
        if (!reset && w_beat_ok) begin
            r_data[{r_fill_idx, r_beat}] <= mem_rdata;
            if (w_last) begin
                r_tag[r_fill_idx] <= r_fill_tag;
            end
        end
    end

    assign mem_req  = r_mem_req;
    assign mem_addr = r_mem_addr;

`ifdef ICACHE_STATS_EN
    logic [31:0] r_hit_count;
    logic [31:0] r_miss_count;

    // Saturating hit/miss counters; stall cycles are neither.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hit_count  <= 32'd0;
            r_miss_count <= 32'd0;
        end else begin
            if (w_hit && (r_hit_count != 32'hFFFF_FFFF)) begin
                r_hit_count <= r_hit_count + 32'd1;
            end
            if (w_miss && (r_miss_count != 32'hFFFF_FFFF)) begin
                r_miss_count <= r_miss_count + 32'd1;
            end
        end
    end

    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;
`endif

endmodule
